// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin arbiter sharing one Wishbone B3 slave bus between NM masters.
//   A master keeps the grant for the whole bus cycle, so locked and
//   back-to-back transfers are never split. A watchdog ends a hung slave
//   transfer with an error so a missing ack cannot stall a master forever.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we/m_lock  per-master control (NM bits each)
//   m_adr, m_sel, m_dat_o    packed per-master address/select/write data
//   m_dat_i               read data broadcast to all masters
//   m_ack/m_err/m_rty     per-master termination, only the granted master sees it
//   s_*                   slave-side bus
//   gnt                   registered one-hot grant
//   timeout               one-cycle pulse when the watchdog fires
module wb_rr_arbiter #(
  parameter int NM        = 2,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int TO_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  input  logic [NM-1:0]        m_we,
  input  logic [NM-1:0]        m_lock,
  input  logic [NM*AW-1:0]     m_adr,
  input  logic [NM*DW/8-1:0]   m_sel,
  input  logic [NM*DW-1:0]     m_dat_o,
  output logic [DW-1:0]        m_dat_i,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_err,
  output logic [NM-1:0]        m_rty,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic                 s_lock,
  output logic [AW-1:0]        s_adr,
  output logic [DW/8-1:0]      s_sel,
  output logic [DW-1:0]        s_dat_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack,
  input  logic                 s_err,
  input  logic                 s_rty,
  output logic [NM-1:0]        gnt,
  output logic                 timeout
);

  localparam int SW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] winner;
  logic [NM-1:0] gnt_nxt;
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic          busy;
  logic          own_cyc;
  logic          own_stb;
  logic          term;
  logic          wd_fire;

  assign busy    = (state == BUSY);
  assign own_cyc = busy & m_cyc[owner];
  // stb without cyc never reaches the slave
  assign own_stb = own_cyc & m_stb[owner];
  assign term    = s_ack | s_err | s_rty;
  // A slave termination in the last allowed cycle wins over the watchdog.
  assign wd_fire = (TO_CYCLES != 0) && own_stb && !term &&
                   (wd_cnt == CW'(TO_CYCLES - 1));
  assign timeout = wd_fire;
  assign m_dat_i = s_dat_i;

  // Round-robin pick: the requester with the smallest distance after 'last'
  // wins, so the previous owner ranks lowest.
  always_comb begin : pick
    int best;
    int d;
    best   = NM;
    d      = 0;
    winner = last;
    for (int i = 0; i < NM; i++) begin
      d = i - int'(last) - 1;
      if (d < 0) d = d + NM;
      if (m_cyc[i] && d < best) begin
        best   = d;
        winner = IW'(i);
      end
    end
  end

  always_comb begin : fsm
    state_nxt  = state;
    owner_nxt  = owner;
    last_nxt   = last;
    gnt_nxt    = gnt;
    wd_cnt_nxt = wd_cnt;
    case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        gnt_nxt    = '0;
        if (|m_cyc) begin
          state_nxt       = BUSY;
          owner_nxt       = winner;
          last_nxt        = winner;
          gnt_nxt[winner] = 1'b1;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          wd_cnt_nxt = '0;
        end else if (term || wd_fire) begin
          wd_cnt_nxt = '0;
        end else if (own_stb && wd_cnt != '1) begin
          // saturate rather than wrap; only matters with the watchdog disabled
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= IW'(NM - 1);
      gnt    <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      gnt    <= gnt_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // Slave-side mux and termination routing; everything is 0 outside BUSY.
  always_comb begin : route
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_lock  = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_o = '0;
    m_ack   = '0;
    m_err   = '0;
    m_rty   = '0;
    if (busy) begin
      s_cyc  = own_cyc;
      s_stb  = own_stb;
      s_we   = m_we[owner];
      s_lock = m_lock[owner];
      for (int i = 0; i < NM; i++) begin
        if (owner == IW'(i)) begin
          s_adr    = m_adr[i*AW +: AW];
          s_sel    = m_sel[i*SW +: SW];
          s_dat_o  = m_dat_o[i*DW +: DW];
          m_ack[i] = s_ack;
          m_err[i] = s_err | wd_fire;
          m_rty[i] = s_rty;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM-1:0]    m_cyc, m_stb, m_we, m_lock;
  logic [NM*AW-1:0] m_adr;
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_dat_o;
  logic [DW-1:0]    m_dat_i;
  logic [NM-1:0]    m_ack, m_err, m_rty;
  logic             s_cyc, s_stb, s_we, s_lock;
  logic [AW-1:0]    s_adr;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_o, s_dat_i;
  logic             s_ack, s_err, s_rty;
  logic [NM-1:0]    gnt;
  logic             timeout;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_lock(m_lock),
    .m_adr(m_adr), .m_sel(m_sel), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_lock(s_lock),
    .s_adr(s_adr), .s_sel(s_sel), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .gnt(gnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- helpers ----------------
  function automatic logic bitof(input logic [NM-1:0] v, input int i);
    logic [NM-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [NM-1:0] onehot(input int i);
    logic [NM-1:0] t;
    t = {{(NM-1){1'b0}}, 1'b1};
    return t << i;
  endfunction

  function automatic logic [AW-1:0] adr_of(input int i);
    logic [NM*AW-1:0] t;
    t = m_adr >> (i * AW);
    return t[AW-1:0];
  endfunction

  function automatic logic [SW-1:0] sel_of(input int i);
    logic [NM*SW-1:0] t;
    t = m_sel >> (i * SW);
    return t[SW-1:0];
  endfunction

  function automatic logic [DW-1:0] dat_of(input int i);
    logic [NM*DW-1:0] t;
    t = m_dat_o >> (i * DW);
    return t[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bus-level view: is some master owning the bus, which one, who won last,
  // and how many consecutive unanswered strobe cycles the owner has had.
  bit md_busy  = 1'b0;
  int md_owner = 0;
  int md_last  = NM - 1;
  int md_stall = 0;

  function automatic bit md_term();
    return s_ack || s_err || s_rty;
  endfunction

  function automatic bit md_stb();
    return md_busy && bitof(m_cyc, md_owner) && bitof(m_stb, md_owner);
  endfunction

  function automatic bit md_fire();
    return md_stb() && !md_term() && (md_stall == TO - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy  = 1'b0;
      md_owner = 0;
      md_last  = NM - 1;
      md_stall = 0;
    end else if (!md_busy) begin
      md_stall = 0;
      for (int k = 1; k <= NM; k++) begin
        if (!md_busy && bitof(m_cyc, (md_last + k) % NM)) begin
          md_busy  = 1'b1;
          md_owner = (md_last + k) % NM;
        end
      end
      if (md_busy) md_last = md_owner;
    end else if (!bitof(m_cyc, md_owner)) begin
      md_busy  = 1'b0;
      md_stall = 0;
    end else if (md_term() || md_fire()) begin
      md_stall = 0;
    end else if (md_stb()) begin
      md_stall = md_stall + 1;
    end
  end

  // ---------------- literal pins set by the directed scenarios ----------------
  bit            pin_en = 1'b0;
  bit            pin_adr_en = 1'b0;
  bit            pin_dat_en = 1'b0;
  string         pin_tag = "";
  logic [NM-1:0] pin_gnt, pin_ack, pin_err;
  logic          pin_scyc, pin_to;
  logic [AW-1:0] pin_adr;
  logic [DW-1:0] pin_dat;

  task automatic pin(input string tag, input logic [NM-1:0] g, input logic sc,
                     input logic [NM-1:0] a, input logic [NM-1:0] e, input logic to);
    pin_tag  = tag;
    pin_gnt  = g;
    pin_scyc = sc;
    pin_ack  = a;
    pin_err  = e;
    pin_to   = to;
    pin_en   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pin_en     = 1'b0;
    pin_adr_en = 1'b0;
    pin_dat_en = 1'b0;
  endtask

  // ---------------- compare process ----------------
  logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
  logic          e_fire, e_stb;

  always @(negedge clk) begin
    if (rst_n) begin
      e_stb  = md_stb();
      e_fire = md_fire();
      e_gnt  = md_busy ? onehot(md_owner) : '0;
      e_ack  = (md_busy && s_ack) ? onehot(md_owner) : '0;
      e_err  = (md_busy && (s_err || e_fire)) ? onehot(md_owner) : '0;
      e_rty  = (md_busy && s_rty) ? onehot(md_owner) : '0;
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("s_cyc", 64'(s_cyc), 64'(md_busy && bitof(m_cyc, md_owner)));
      chk("s_stb", 64'(s_stb), 64'(e_stb));
      chk("s_we", 64'(s_we), 64'(md_busy && bitof(m_we, md_owner)));
      chk("s_lock", 64'(s_lock), 64'(md_busy && bitof(m_lock, md_owner)));
      chk("s_adr", 64'(s_adr), md_busy ? 64'(adr_of(md_owner)) : 64'd0);
      chk("s_sel", 64'(s_sel), md_busy ? 64'(sel_of(md_owner)) : 64'd0);
      chk("s_dat_o", 64'(s_dat_o), md_busy ? 64'(dat_of(md_owner)) : 64'd0);
      chk("m_ack", 64'(m_ack), 64'(e_ack));
      chk("m_err", 64'(m_err), 64'(e_err));
      chk("m_rty", 64'(m_rty), 64'(e_rty));
      chk("timeout", 64'(timeout), 64'(e_fire));
      chk("m_dat_i", 64'(m_dat_i), 64'(s_dat_i));
    end
    if (pin_en) begin
      chk({pin_tag, ".gnt"}, 64'(gnt), 64'(pin_gnt));
      chk({pin_tag, ".s_cyc"}, 64'(s_cyc), 64'(pin_scyc));
      chk({pin_tag, ".m_ack"}, 64'(m_ack), 64'(pin_ack));
      chk({pin_tag, ".m_err"}, 64'(m_err), 64'(pin_err));
      chk({pin_tag, ".timeout"}, 64'(timeout), 64'(pin_to));
      if (pin_adr_en) chk({pin_tag, ".s_adr"}, 64'(s_adr), 64'(pin_adr));
      if (pin_dat_en) chk({pin_tag, ".m_dat_i"}, 64'(m_dat_i), 64'(pin_dat));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [NM-1:0] nc, ns;
  bit deaf;
  int r;

  initial begin
    idle_inputs();
    m_adr   = 64'h0000_0020_0000_0010;
    m_sel   = 16'hF0FF;
    m_dat_o = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    s_dat_i = '0;
    step();
    // reset state
    pin("rst", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // single master write, ack after 3 cycles
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    pin("t1.req", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t1.gnt", 2'b01, 1'b1, 2'b00, 2'b00, 1'b0);
    pin_adr = 32'h10; pin_adr_en = 1'b1;
    step();
    step();
    s_ack = 1'b1;
    pin("t1.ack", 2'b01, 1'b1, 2'b01, 2'b00, 1'b0);
    step();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    pin("t1.drop", 2'b01, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t1.idle", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();

    // both request after reset: 0, then 1, then 0
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    pin("t2.req", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    s_ack = 1'b1;
    pin("t2.g0", 2'b01, 1'b1, 2'b01, 2'b00, 1'b0);
    step();
    s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
    pin("t2.rel0", 2'b01, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t2.gap", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    pin("t2.g1", 2'b10, 1'b1, 2'b10, 2'b00, 1'b0);
    step();
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
    pin("t2.rel1", 2'b10, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t2.gap2", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t2.g0b", 2'b01, 1'b1, 2'b00, 2'b00, 1'b0);
    step();
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
    step();

    // master 0 holds cyc over 4 back-to-back reads while master 1 waits
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00;
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_dat_i = (k % 2 == 0) ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'h5A5A_5A5A_5A5A_5A5A;
      s_ack = 1'b1;
      pin("t3.rd", 2'b01, 1'b1, 2'b01, 2'b00, 1'b0);
      pin_dat = s_dat_i; pin_dat_en = 1'b1;
      step();
    end
    s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
    pin("t3.rel", 2'b01, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t3.gap", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t3.g1", 2'b10, 1'b1, 2'b00, 2'b00, 1'b0);
    step();
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
    step();

    // watchdog: slave never answers, fires in the 8th stb cycle
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int i = 1; i <= TO; i++) begin
      pin("t4.wd", 2'b01, 1'b1, 2'b00, (i == TO) ? 2'b01 : 2'b00, (i == TO) ? 1'b1 : 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      pin("t4.after", 2'b01, 1'b1, 2'b00, 2'b00, 1'b0);
      step();
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    step();
    step();

    // slave ack in the cycle the watchdog would fire
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int i = 1; i <= TO; i++) begin
      s_ack = (i == TO);
      pin("t5.race", 2'b01, 1'b1, (i == TO) ? 2'b01 : 2'b00, 2'b00, 1'b0);
      step();
    end
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    step();
    step();

    // async reset in the middle of a busy cycle owned by master 1
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    s_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    pin("t6.rst", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    rst_n = 1'b1; s_ack = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    pin("t6.rel", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    step();
    pin("t6.g0", 2'b01, 1'b1, 2'b00, 2'b00, 1'b0);
    step();
    idle_inputs();
    step();
    step();

    // randomized traffic
    deaf = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      deaf = ((n / 250) % 3 == 2);
      nc = m_cyc;
      ns = m_stb;
      for (int i = 0; i < NM; i++) begin
        if (bitof(nc, i)) begin
          if ($urandom_range(0, deaf ? 40 : 5) == 0) begin
            nc = nc & ~onehot(i);
            ns = ns & ~onehot(i);
          end else if ($urandom_range(0, 3) != 0) begin
            ns = ns | onehot(i);
          end else begin
            ns = ns & ~onehot(i);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          nc = nc | onehot(i);
          ns = ns | onehot(i);
        end else if ($urandom_range(0, 7) == 0) begin
          ns = ns | onehot(i);
        end else begin
          ns = ns & ~onehot(i);
        end
      end
      m_cyc   = nc;
      m_stb   = ns;
      m_we    = NM'($urandom);
      m_lock  = NM'($urandom);
      m_adr   = {$urandom, $urandom};
      m_sel   = 16'($urandom);
      m_dat_o = {$urandom, $urandom, $urandom, $urandom};
      s_dat_i = {$urandom, $urandom};
      r       = $urandom_range(0, 9);
      s_ack   = !deaf && (r < 3);
      s_err   = !deaf && (r == 3);
      s_rty   = !deaf && (r == 4);
      step();
    end

    idle_inputs();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone B3 slave bus between N Wishbone masters.
- Typical masters: Avalon-to-Wishbone bridge instances, e.g. the HPS bridge plus a video DMA bridge.
- Grant is held for a whole bus cycle (`cyc` high), so locked and back-to-back transfers are never split.
- A watchdog terminates hung slave transfers with an error, so a missing `ack` cannot deadlock the HPS.

Parameters:
- NM, 2, number of masters (2..8).
- AW, 32, address width.
- DW, 64, data width; select width is DW/8.
- TO_CYCLES, 255, watchdog limit in cycles of stb without ack/err/rty; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_cyc  in  NM  per-master cyc
- m_stb  in  NM  per-master stb
- m_we  in  NM  per-master we
- m_lock  in  NM  per-master lock
- m_adr  in  NM*AW  packed addresses; master i at [i*AW +: AW]
- m_sel  in  NM*DW/8  packed byte selects
- m_dat_o  in  NM*DW  packed write data
- m_dat_i  out  DW  read data, broadcast to all masters
- m_ack  out  NM  per-master ack
- m_err  out  NM  per-master err
- m_rty  out  NM  per-master rty
- s_cyc, s_stb, s_we, s_lock  out  1  slave-side control
- s_adr  out  AW  slave address
- s_sel  out  DW/8  slave byte select
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_ack, s_err, s_rty  in  1  slave termination
- gnt  out  NM  registered one-hot grant
- timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt=0, last=NM-1 (master 0 wins first), wd_cnt=0, timeout=0.
  - All s_* and m_ack/m_err/m_rty are 0.
  - m_dat_i is don't-care but equals s_dat_i.
- FSM:
  - IDLE:
    - If |m_cyc, pick the first requesting index scanning last+1, last+2, …, wrapping modulo NM.
    - Register gnt=onehot(winner) and last=winner; go to BUSY.
    - With no request, stay in IDLE, gnt=0.
  - BUSY:
    - s_cyc, s_stb, s_we, s_lock, s_adr, s_sel and s_dat_o are combinational muxes of the granted master, qualified so s_cyc = m_cyc[g].
    - s_ack, s_err and s_rty are routed only to m_*[g]; all other masters see 0.
  - BUSY -> IDLE when m_cyc[g]=0 at the clock edge; gnt clears on that edge.
  - Grant never changes while m_cyc[g]=1, regardless of other requests.
- Latency:
  - m_cyc rising in cycle t (bus IDLE) gives gnt and s_cyc in cycle t+1.
  - Handover between masters costs exactly one idle cycle (BUSY -> IDLE -> BUSY).
  - No combinational path from m_cyc to gnt.
- Fairness:
  - With all NM masters continuously requesting, grants rotate 0,1,…,NM-1,0.
  - Worst-case wait is NM-1 bus cycles.
- Watchdog:
  - In BUSY, wd_cnt increments each cycle with s_stb=1 and s_ack|s_err|s_rty=0.
  - wd_cnt clears on any termination or on leaving BUSY.
  - When wd_cnt==TO_CYCLES-1 with no termination, the arbiter drives m_err[g]=1 for that cycle, regardless of the slave.
  - The same cycle: timeout=1 pulse and wd_cnt clears.
  - The slave still sees stb; the master drops it per the B3 error rule.
  - A slave termination in the firing cycle takes precedence: no timeout, and the slave's signal is forwarded.
  - wd_cnt width is clog2(TO_CYCLES+1); it saturates and does not wrap.
- Simultaneous events:
  - Requests arriving in the same cycle as a release are not seen until IDLE; the released master may win again only if it is the sole requester.
  - m_stb without m_cyc is ignored.
- Reset mid-transfer drops all outputs to 0 immediately (async).

Test Plan:
- Single master 0: cyc/stb write adr=0x10, slave acks after 3 cycles -> gnt=01 at t+1, s_adr=0x10, m_ack[0] pulses once, m_ack[1]=0, gnt=00 one cycle after cyc drops.
- Both masters request in the same cycle after reset -> master 0 granted first; after release, 1 idle cycle, then master 1 granted; a third round grants master 0.
- Master 0 holds cyc over 4 back-to-back acked reads (s_dat_i=0xA5A5…, 0x5A5A…) while master 1 requests -> gnt stays 01 for all 4 acks, m_dat_i matches each; master 1 is granted only after release.
- TO_CYCLES=8, slave never responds -> m_err[0]=1 and timeout=1 in the 8th stb cycle, exactly one pulse, wd_cnt=0 afterwards.
- Slave acks in the same cycle the watchdog would fire -> m_ack[0]=1, m_err[0]=0, timeout=0.
- rst_n asserted mid-BUSY (async, between edges) -> s_cyc, gnt, m_ack all 0 immediately; after release, master 0 has priority again.
